// File: rtl/complex_fir_decim.sv
// Complex low-pass FIR decimator: circular delay line per rail, one time-shared MAC per rail,
// and a rounded, saturated output every DECIM accepted samples.
module complex_fir_decim #(
    parameter int IN_W   = 22,
    parameter int OUT_W  = 24,
    parameter int COEF_W = 16,
    parameter int N_TAPS = 16,
    parameter int DECIM  = 4,
    parameter int SHIFT  = 15,
    parameter logic [N_TAPS-1:0][COEF_W-1:0] COEFFS = {N_TAPS{16'd2048}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_real,
    input  logic [IN_W-1:0]  in_imag,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_real,
    output logic [OUT_W-1:0] out_imag,
    output logic             overrun
);
    localparam int PTR_W  = $clog2(N_TAPS);
    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PROD_W = IN_W + COEF_W;
    localparam int ACC_W  = PROD_W + PTR_W;

    localparam logic [PH_W-1:0]        PH_LAST  = PH_W'(DECIM - 1);
    localparam logic [PTR_W-1:0]       TAP_LAST = PTR_W'(N_TAPS - 1);
    localparam logic signed [ACC_W:0]  HALF     = (ACC_W + 1)'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W:0]  OUT_MAX  = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0]  OUT_MIN  = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

    state_t                    state_reg;
    state_t                    state_next;
    logic [PTR_W-1:0]          wr_ptr_reg;
    logic [PTR_W-1:0]          newest_reg;
    logic [PTR_W-1:0]          tap_reg;
    logic [PTR_W-1:0]          rd_idx;
    logic [PH_W-1:0]           phase_reg;
    logic signed [ACC_W-1:0]   acc_r_reg;
    logic signed [ACC_W-1:0]   acc_i_reg;
    logic signed [IN_W-1:0]    line_r [N_TAPS];
    logic signed [IN_W-1:0]    line_i [N_TAPS];
    logic signed [COEF_W-1:0]  coef [N_TAPS];
    logic signed [PROD_W-1:0]  prod_r;
    logic signed [PROD_W-1:0]  prod_i;
    logic signed [ACC_W-1:0]   prod_r_ext;
    logic signed [ACC_W-1:0]   prod_i_ext;
    logic                      accept;
    logic                      trigger;
    logic                      out_valid_reg;
    logic                      overrun_reg;
    logic [OUT_W-1:0]          out_real_reg;
    logic [OUT_W-1:0]          out_imag_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_TAPS; gi++) begin : g_coef
            assign coef[gi] = COEFFS[gi];
        end
    endgenerate

    assign in_ready = (state_reg == IDLE);
    assign accept   = in_valid && in_ready;
    assign trigger  = accept && (phase_reg == PH_LAST);

    // newest_reg points at x[n]; walking backwards through the ring gives x[n-k].
    assign rd_idx     = newest_reg - tap_reg;
    assign prod_r     = coef[tap_reg] * line_r[rd_idx];
    assign prod_i     = coef[tap_reg] * line_i[rd_idx];
    assign prod_r_ext = {{PTR_W{prod_r[PROD_W-1]}}, prod_r};
    assign prod_i_ext = {{PTR_W{prod_i[PROD_W-1]}}, prod_i};

    function automatic logic [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] biased;
        logic signed [ACC_W:0] shifted;
        logic [OUT_W-1:0]      result;
        biased  = $signed({acc[ACC_W-1], acc}) + HALF;
        shifted = biased >>> SHIFT;
        if (shifted > OUT_MAX) begin
            result = OUT_MAX[OUT_W-1:0];
        end else if (shifted < OUT_MIN) begin
            result = OUT_MIN[OUT_W-1:0];
        end else begin
            result = shifted[OUT_W-1:0];
        end
        return result;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (trigger) state_next = MAC;
            MAC:     if (tap_reg == TAP_LAST) state_next = ROUND;
            ROUND:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg    <= '0;
            newest_reg    <= '0;
            phase_reg     <= '0;
            tap_reg       <= '0;
            acc_r_reg     <= '0;
            acc_i_reg     <= '0;
            out_real_reg  <= '0;
            out_imag_reg  <= '0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) begin
                line_r[i] <= '0;
                line_i[i] <= '0;
            end
        end else begin
            out_valid_reg <= 1'b0;
            if (in_valid && !in_ready) begin
                overrun_reg <= 1'b1;
            end
            if (accept) begin
                line_r[wr_ptr_reg] <= in_real;
                line_i[wr_ptr_reg] <= in_imag;
                wr_ptr_reg         <= wr_ptr_reg + 1'b1;
                phase_reg          <= (phase_reg == PH_LAST) ? '0 : phase_reg + 1'b1;
            end
            if (trigger) begin
                newest_reg <= wr_ptr_reg;
                tap_reg    <= '0;
                acc_r_reg  <= '0;
                acc_i_reg  <= '0;
            end
            case (state_reg)
                MAC: begin
                    acc_r_reg <= acc_r_reg + prod_r_ext;
                    acc_i_reg <= acc_i_reg + prod_i_ext;
                    tap_reg   <= tap_reg + 1'b1;
                end
                ROUND: begin
                    out_real_reg  <= round_sat(acc_r_reg);
                    out_imag_reg  <= round_sat(acc_i_reg);
                    out_valid_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_real  = out_real_reg;
    assign out_imag  = out_imag_reg;
    assign overrun   = overrun_reg;

endmodule

// File: doc/complex_fir_decim.md
Name: complex_fir_decim

Overview:
- Complex baseband low-pass FIR decimator. It sits directly downstream of the complex mixer and consumes its 22-bit signed I/Q products.
- It stores incoming samples in a circular delay line. Every DECIM accepted samples it computes one filtered output with a time-shared MAC (one multiplier per rail).
- Output is rounded, saturated complex samples with a valid strobe.

Parameters:
- IN_W, 22, input sample width per rail (signed)
- OUT_W, 24, output sample width per rail (signed)
- COEF_W, 16, coefficient width, signed Q1.(COEF_W-1)
- N_TAPS, 16, filter length (power of 2, ≥ DECIM)
- DECIM, 4, decimation ratio (≥ 1)
- SHIFT, 15, accumulator right shift before output
- COEFFS, all 2048, array[N_TAPS] of signed COEF_W coefficients h[k]; the default is a 16-tap boxcar of gain 1.0

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid  in  1  input sample present this cycle
- in_ready  out  1  block can accept a sample this cycle
- in_real  in  IN_W  signed I sample
- in_imag  in  IN_W  signed Q sample
- out_valid  out  1  one-cycle strobe, output sample valid
- out_real  out  OUT_W  signed filtered I
- out_imag  out  OUT_W  signed filtered Q
- overrun  out  1  sticky: a sample arrived while in_ready=0

Behaviour:
- Reset (async assert, synchronous-safe deassert):
  - All outputs = 0; overrun = 0; in_ready = 1 once state is IDLE.
  - Delay line cleared to zero; write pointer = 0; phase counter = 0; accumulators = 0.
- Accept: in_valid & in_ready.
  - Sample is written into the delay line at the write pointer; pointer increments mod N_TAPS.
  - Phase counter increments mod DECIM.
- Drop: in_valid & !in_ready.
  - Sample is discarded, with no write and no phase change.
  - overrun is set to 1 and held until reset.
- FSM states: IDLE, MAC, ROUND.
  - IDLE: in_ready = 1. An accept with phase == DECIM-1 → MAC. Tap index k = 0; both accumulators are cleared at the same edge.
  - MAC: in_ready = 0. Lasts exactly N_TAPS cycles. Each cycle: acc_r += h[k]*x_r[n-k] and acc_i += h[k]*x_i[n-k], where x[n] is the sample just accepted. Then k++. After k = N_TAPS-1 → ROUND.
  - ROUND: in_ready = 0. Each rail computes (acc + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf. The result saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and is registered into out_real/out_imag. out_valid = 1 for the cycle after this edge. Next state is IDLE.
- Filter equation: y[m] = sum over k=0..N_TAPS-1 of h[k]·x[mDECIM+DECIM-1-k]. x before reset counts as 0.
- Widths:
  - Product is IN_W+COEF_W bits.
  - Accumulator is IN_W+COEF_W+log2(N_TAPS) bits (42 by default), so it never overflows.
- Timing and latency:
  - Trigger sample is accepted at edge E0. out_valid is high in the cycle after edge E0+N_TAPS+1 (18 cycles after acceptance by default).
  - in_ready is low for N_TAPS+1 cycles per output.
- Output hold and simultaneity:
  - out_real/out_imag hold their value between strobes.
  - out_valid is never high in two consecutive cycles.
  - in_valid in the same cycle the FSM returns to IDLE is accepted normally.
- Reset mid-MAC/ROUND: computation is abandoned, no out_valid, and all state is cleared as at reset.
- DECIM = 1: every accept triggers a computation.

Test Plan:
- Impulse: in_real = 1000 on one accept, then zeros. Defaults, samples sent whenever in_ready = 1. Expected: four consecutive outputs with out_real = 63 (2048000+16384 >> 15), then 0. out_imag = 0 throughout. overrun = 0.
- DC: constant in_real = 100000, in_imag = -100000. Expected: from the 4th output on, out_real = 100000 and out_imag = -100000 exactly. Outputs 1–3 ramp as 25000, 50000, 75000 and their negatives.
- Saturation: COEFFS all 32767, in_real = 2097151, in_imag = -2097152 held. Expected: steady-state out_real = 8388607 and out_imag = -8388608. No wrap at any point.
- Timing/handshake: accept the 4th sample at cycle 0. Expected: in_ready = 0 during cycles 1–17. out_valid is a single-cycle pulse at cycle 18. in_ready is back to 1 at cycle 18.
- Overrun: drive in_valid = 1 continuously, ignoring in_ready. Expected: overrun rises on the first cycle with in_ready = 0 and stays 1. The phase counter advances only on accepted samples, giving one output per 4 accepts.
- Reset mid-MAC: assert reset at MAC cycle 5. Expected: outputs immediately 0 and no out_valid. After release, the impulse test reproduces exactly with no residue from earlier samples.
